// File: rtl/spi_master_if.sv
// Host-request and SPI pin bundle for spi_master.
// master = host/bench side (drives requests and MISO), slave = spi_master itself.
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       seq_err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (output start, cmd, din, MISO,
                  input  ready, rdata, rdata_valid, seq_err, SS_n, MOSI);
  modport slave  (input  start, cmd, din, MISO,
                  output ready, rdata, rdata_valid, seq_err, SS_n, MOSI);
endinterface

// File: rtl/spi_master.sv
// SPI initiator: selector bit + 10-bit command word on MOSI, optional 8-bit MISO read-back.
// SPI_MASTER_SEQ_CHECK_EN enables the read-address/read-data sequence checker (seq_err).
module spi_master #(
  parameter int READ_GAP = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEL, SHIFT, GAP, RECV, DONE} state_t;

  localparam logic [3:0] GAP_LAST  = 4'(READ_GAP - 1);
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] w_q, w_d;
  logic [1:0] cmd_q, cmd_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdata_valid_q, rdata_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       ready_q, ready_d;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       flag_q, flag_d;
  logic       seq_err_q, seq_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    w_d           = w_q;
    cmd_d         = cmd_q;
    rx_d          = rx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    flag_d        = flag_q;
    seq_err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        w_d     = {bus.cmd, bus.din};
        cmd_d   = bus.cmd;
        cnt_d   = '0;
        state_d = SEL;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        seq_err_d = (bus.cmd == 2'b11) && !flag_q;
`endif
      end
      SEL: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      // W shifts left so MOSI always takes bit 9 of the register
      SHIFT: if (cnt_q == 4'd9) begin
        cnt_d = '0;
        w_d   = {w_q[8:0], 1'b0};
        if (cmd_q == 2'b11) state_d = GAP;
        else begin
          state_d = DONE;
`ifdef SPI_MASTER_SEQ_CHECK_EN
          if (cmd_q == 2'b10) flag_d = 1'b1;
`endif
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
        w_d   = {w_q[8:0], 1'b0};
      end
      GAP: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = RECV;
      end else cnt_d = cnt_q + 4'd1;
      RECV: begin
        rx_d = {rx_q[6:0], bus.MISO};
        if (cnt_q == 4'd7) begin
          cnt_d         = '0;
          rdata_d       = rx_d;
          rdata_valid_d = 1'b1;
          state_d       = DONE;
`ifdef SPI_MASTER_SEQ_CHECK_EN
          flag_d        = 1'b0;
`endif
        end else cnt_d = cnt_q + 4'd1;
      end
      DONE: if (cnt_q == IDLE_LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt_q + 4'd1;
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state so every output is a flop
    ss_n_d  = (state_d == IDLE) || (state_d == DONE);
    ready_d = (state_d == IDLE);
    mosi_d  = ((state_d == SEL) || (state_d == SHIFT)) ? w_d[9] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      w_q           <= '0;
      cmd_q         <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ss_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      w_q           <= w_d;
      cmd_q         <= cmd_d;
      rx_q          <= rx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ss_n_q        <= ss_n_d;
      mosi_q        <= mosi_d;
      ready_q       <= ready_d;
    end
  end

`ifdef SPI_MASTER_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      seq_err_q <= seq_err_d;
    end
  end
  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.SS_n        = ss_n_q;
  assign bus.MOSI        = mosi_q;
  assign bus.ready       = ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: frame-level timing model plus a behavioural SPI/RAM slave.
module tb_spi_master;
  localparam int RG = 2;
  localparam int IG = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if bus();
  spi_master #(.READ_GAP(RG), .IDLE_GAP(IG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ref_*: intended host-side view; slv_*: what the slave decodes from MOSI
  logic [7:0] ref_mem [256];
  logic [7:0] slv_mem [256];
  logic [7:0] ref_addr, ref_raddr, slv_addr, slv_raddr, ref_rdata;
  bit         ref_flag;

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input bit ign, input bit hold);
    int n, len;
    logic [9:0] w, seen;
    logic [7:0] rbyte;
    bit exp_seq, e_ss, e_mosi, e_rdy, e_vld, e_err;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_wait: ready=%b want 1", bus.ready); end
    w   = {c, d};
    len = (c == 2'b11) ? 20 + RG : 12;
    exp_seq = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    exp_seq = (c == 2'b11) && !ref_flag;
`endif
    rbyte     = slv_mem[slv_raddr];
    bus.cmd   = c;
    bus.din   = d;
    bus.start = 1'b1;
    @(posedge clk);
    seen = '0;
    for (int k = 1; k <= len + IG; k++) begin
      @(negedge clk);
      if (hold) bus.start = 1'b1;
      else begin
        bus.start = ign && (k == 3 || k == 8);
        if (bus.start) begin bus.cmd = 2'($urandom); bus.din = 8'($urandom); end
      end
      e_ss   = !(k < len);
      e_mosi = (k == 1) ? w[9] : ((k >= 2 && k <= 11) ? w[11-k] : 1'b0);
      e_rdy  = (k >= len + IG);
      e_vld  = (c == 2'b11) && (k == len);
      e_err  = exp_seq && (k == 1);
      if (e_vld) ref_rdata = ref_mem[ref_raddr];
      checks++;
      if (bus.SS_n !== e_ss) begin errors++; $display("FAIL ss_n cmd=%0d k=%0d: got %b want %b", c, k, bus.SS_n, e_ss); end
      checks++;
      if (bus.MOSI !== e_mosi) begin errors++; $display("FAIL mosi cmd=%0d k=%0d: got %b want %b", c, k, bus.MOSI, e_mosi); end
      checks++;
      if (bus.ready !== e_rdy) begin errors++; $display("FAIL ready cmd=%0d k=%0d: got %b want %b", c, k, bus.ready, e_rdy); end
      checks++;
      if (bus.rdata_valid !== e_vld) begin errors++; $display("FAIL rdata_valid cmd=%0d k=%0d: got %b want %b", c, k, bus.rdata_valid, e_vld); end
      checks++;
      if (bus.rdata !== ref_rdata) begin errors++; $display("FAIL rdata cmd=%0d k=%0d: got %h want %h", c, k, bus.rdata, ref_rdata); end
      checks++;
      if (bus.seq_err !== e_err) begin errors++; $display("FAIL seq_err cmd=%0d k=%0d: got %b want %b", c, k, bus.seq_err, e_err); end
      if (k >= 2 && k <= 11) seen[11-k] = bus.MOSI;
      if (k >= 12 + RG && k <= 19 + RG) bus.MISO = rbyte[19 + RG - k];
      else bus.MISO = 1'($urandom);
    end
    case (c)
      2'b00: ref_addr = d;
      2'b01: ref_mem[ref_addr] = d;
      2'b10: begin ref_raddr = d; ref_flag = 1'b1; end
      default: ref_flag = 1'b0;
    endcase
    case (seen[9:8])
      2'b00: slv_addr = seen[7:0];
      2'b01: slv_mem[slv_addr] = seen[7:0];
      2'b10: slv_raddr = seen[7:0];
      default: ;
    endcase
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cmd = '0; bus.din = '0; bus.MISO = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.SS_n, bus.MOSI, bus.ready, bus.rdata_valid, bus.seq_err} !== 5'b10100) begin
      errors++; $display("FAIL reset_pins: got %b want 10100", {bus.SS_n, bus.MOSI, bus.ready, bus.rdata_valid, bus.seq_err});
    end
    checks++;
    if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.SS_n, bus.ready} !== 2'b11) begin errors++; $display("FAIL post_reset_idle: got %b want 11", {bus.SS_n, bus.ready}); end
  endtask

  task automatic test_reset_mid();
    bus.cmd = 2'b00; bus.din = 8'($urandom); bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin @(negedge clk); bus.start = 1'b0; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.SS_n, bus.MOSI, bus.ready, bus.rdata_valid, bus.seq_err} !== 5'b10100) begin
      errors++; $display("FAIL mid_reset_pins: got %b want 10100", {bus.SS_n, bus.MOSI, bus.ready, bus.rdata_valid, bus.seq_err});
    end
    checks++;
    if (bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_rdata: got %h want 00", bus.rdata); end
    ref_rdata = 8'h00;
    ref_flag  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(2'b11, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_write_addr();
    run_frame(2'b00, 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_write_data();
    run_frame(2'b01, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (slv_mem[8'h3C] !== 8'hA5) begin errors++; $display("FAIL ram_write: got %h want a5", slv_mem[8'h3C]); end
  endtask

  task automatic test_read_back();
    run_frame(2'b10, 8'h3C, 1'b0, 1'b0);
    run_frame(2'b11, 8'($urandom), 1'b0, 1'b0);
    checks++;
    if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL read_back: got %h want a5", bus.rdata); end
  endtask

  task automatic test_ignored_start();
    run_frame(2'b00, 8'($urandom), 1'b1, 1'b0);
    run_frame(2'b11, 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(2'b10, 8'($urandom), 1'b0, 1'b1);
    run_frame(2'b11, 8'($urandom), 1'b0, 1'b1);
    run_frame(2'b01, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_frame(2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    run_frame(2'b00, 8'h00, 1'b0, 1'b0);
    n_mem_check();
  endtask

  task automatic n_mem_check();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (slv_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ram_image: %0d bytes differ, want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    ref_addr = '0; ref_raddr = '0; slv_addr = '0; slv_raddr = '0;
    ref_rdata = '0; ref_flag = 1'b0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_back();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI initiator that drives the existing SPI-slave/RAM wrapper from the other end of the same 4-wire link. It turns a parallel command request into one SS_n-framed serial transaction: a selector bit followed by a 10-bit command word on MOSI, then, for read-data commands, it captures 8 bits returned on MISO. It sits between a host-side controller or bench sequencer and the slave's MOSI/SS_n/MISO pins, sharing the slave's system clock.

## Interface
- READ_GAP, 2: cycles between the last MOSI bit and the first MISO sample in a read-data frame (≥1).
- IDLE_GAP, 1: minimum cycles SS_n is held high after every frame (≥1).
- clk  in  1  system clock; all logic on rising edge; slave runs on the same clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; accepted only while ready=1.
- cmd  in  2  command: 00 write address, 01 write data, 10 read address, 11 read data.
- din  in  8  address or data payload; for 11 it is don't-care and is sent as given.
- ready  out  1  high in IDLE; new request may be accepted.
- rdata  out  8  byte captured from MISO; holds until the next read-data completion.
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- seq_err  out  1  one-cycle protocol-sequence error pulse (see Configuration).
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave, sampled on rising clk.

## Operation
- States: IDLE, SEL, SHIFT, GAP, RECV, DONE.
- IDLE: SS_n=1, MOSI=0, ready=1. start=1 latches frame word W={cmd,din} (10 bits) and cmd; goes to SEL. start while ready=0 is ignored, no queuing.
- SEL (1 cycle): SS_n=0, MOSI=W[9] (read/write selector bit consumed by the slave's command-check state).
- SHIFT (10 cycles): SS_n=0, MOSI=W[9], W[8], …, W[0]; 4-bit bit counter. On the last bit: cmd=11 → GAP, else → DONE.
- GAP (READ_GAP cycles): SS_n=0, MOSI=0; slave fetches RAM data.
- RECV (8 cycles): SS_n=0, MOSI=0; MISO shifted into an 8-bit register MSB first, one bit per rising edge. After the 8th sample: rdata ← register, rdata_valid=1 for one cycle, → DONE.
- DONE (IDLE_GAP cycles): SS_n=1, MOSI=0, ready=0; then → IDLE.
- Counters saturate at the state's length and reload on state entry; no wrap.
- Reset, asynchronous at any point including mid-frame: state IDLE, SS_n=1, MOSI=0, ready=1, rdata=0x00, rdata_valid=0, seq_err=0, counters and shift registers 0. No partial rdata update.

## Timing
- Cycle 0 = edge where start is sampled with ready=1. ready=0 from cycle 1.
- SS_n low cycles 1..11: cycle 1 selector, cycles 2..11 W[9..0].
- Write-address, write-data and read-address commands: SS_n high from cycle 12; ready=1 at cycle 12+IDLE_GAP (13 at default).
- Read-data command: GAP cycles 12..11+READ_GAP; MISO sampled at the end of cycles 12+READ_GAP..19+READ_GAP (14..21 at default). rdata/rdata_valid and SS_n=1 at cycle 20+READ_GAP (22). ready=1 at cycle 20+READ_GAP+IDLE_GAP (23).
- start held high across ready re-assertion starts a new frame on that cycle (back-to-back).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SPI_MASTER_SEQ_CHECK_EN defined: a flag is set when a read-address (10) frame completes and cleared when a read-data (11) frame completes. Accepting cmd=11 with the flag clear pulses seq_err at cycle 1. The frame is still sent. Reset clears the flag.
- Not defined: no flag; seq_err tied to 0.

## Test plan
- Reset mid-SHIFT (rst_n low at cycle 5) -> SS_n=1, MOSI=0, ready=1, rdata=0x00 immediately; the next start yields a clean full frame.
- Write address: start, cmd=00, din=0x3C -> SS_n low cycles 1..11, MOSI 0 then 00_0011_1100, ready=1 at cycle 13.
- Write data: with wrapper attached, cmd=00 din=0x3C, then cmd=01 din=0xA5 -> RAM location 0x3C holds 0xA5.
- Read back: cmd=10 din=0x3C, then cmd=11 -> rdata=0xA5 with rdata_valid pulsed once at cycle 22 of the read-data frame; SS_n high the same cycle.
- Ignored start: start pulsed at cycles 3 and 8 of a frame -> no effect; frame timing unchanged.
- With SPI_MASTER_SEQ_CHECK_EN: cmd=11 after reset -> seq_err=1 at cycle 1 only. Sequence 10 then 11 -> seq_err stays 0. Without the macro, seq_err=0 throughout.
